// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, data width
// and the legal range of the response latency.
package dmem_pkg;

    localparam int DATA_W      = 64;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Doubleword RAM: synchronous write, asynchronous read, no reset on contents.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the d_mem_* bus: accepts one request at a time, answers after a
// fixed LATENCY with a one-cycle ready pulse. Define DMEM_MISALIGN_ERR_EN to add
// the d_mem_err output that flags and suppresses misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int d_addr_bits = 6,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [d_addr_bits-1:0] d_mem_addr,
    inout  wire  [DATA_W-1:0]      d_mem_data,
    input  logic                   d_mem_we,
    input  logic                   d_mem_req,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic                   d_mem_err,
`endif
    output logic                   d_mem_ready
);

    localparam int IDX_W = d_addr_bits - 3;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               accept;

    logic [IDX_W-1:0]   idx_reg;
    logic               we_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               misalign_reg;

    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  read_value;
    logic               drive_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Request fields are captured only at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_reg      <= d_mem_addr[d_addr_bits-1:3];
            we_reg       <= d_mem_we;
            misalign_reg <= (d_mem_addr[2:0] != 3'b000);
            if (d_mem_we) begin
                wdata_reg <= d_mem_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_mem_req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = (LATENCY == LATENCY_MIN) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign d_mem_ready = (state_reg == RESP);
    assign drive_en    = (state_reg == RESP) && !we_reg;

`ifdef DMEM_MISALIGN_ERR_EN
    assign d_mem_err  = (state_reg == RESP) && misalign_reg;
    // A reset landing on the RESP edge aborts the commit.
    assign ram_we     = (state_reg == RESP) && we_reg && !misalign_reg && !rst;
    assign read_value = misalign_reg ? '0 : ram_rdata;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_reg;
    assign ram_we     = (state_reg == RESP) && we_reg && !rst;
    assign read_value = ram_rdata;
`endif

    assign d_mem_data = drive_en ? read_value : 'z;

    dmem_ram #(
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .widx  (idx_reg),
        .wdata (wdata_reg),
        .ridx  (idx_reg),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for single requests,
// resets and misalignment, and a LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [5:0]  addr2;
    logic        we2, req2, drv2, ready2;
    logic [63:0] d2;
    wire  [63:0] bus2;
    assign bus2 = drv2 ? d2 : 'z;

    logic [5:0]  addr1;
    logic        we1, req1, drv1, ready1;
    logic [63:0] d1;
    wire  [63:0] bus1;
    assign bus1 = drv1 ? d1 : 'z;

`ifdef DMEM_MISALIGN_ERR_EN
    logic err2, err1;
`endif

    int checks = 0;
    int errors = 0;

    dmem_responder #(.d_addr_bits(6), .LATENCY(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .d_mem_addr  (addr2),
        .d_mem_data  (bus2),
        .d_mem_we    (we2),
        .d_mem_req   (req2),
`ifdef DMEM_MISALIGN_ERR_EN
        .d_mem_err   (err2),
`endif
        .d_mem_ready (ready2)
    );

    dmem_responder #(.d_addr_bits(6), .LATENCY(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .d_mem_addr  (addr1),
        .d_mem_data  (bus1),
        .d_mem_we    (we1),
        .d_mem_req   (req1),
`ifdef DMEM_MISALIGN_ERR_EN
        .d_mem_err   (err1),
`endif
        .d_mem_ready (ready1)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; alt replaces the address after acceptance.
    // While the responder must be released the bench drives d2 and expects it back intact.
    task automatic txn(input string tag, input logic [5:0] a, input logic w,
                       input logic [63:0] wd, input logic [5:0] alt, input logic [63:0] exp_rd);
        int cyc;
        bit seen;
        logic [63:0] got;
        @(posedge clk); #1;
        addr2 = a; we2 = w; d2 = w ? wd : 64'h0; drv2 = 1'b1; req2 = 1'b1;
        cyc = 0; seen = 1'b0; got = '0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) addr2 = alt;
            if (ready2 && !w) drv2 = 1'b0;
            @(negedge clk);
            if (ready2) begin
                seen = 1'b1;
                got  = bus2;
                check_value({tag, "_latency"}, 64'(cyc), 64'd2);
                check_value({tag, "_data"}, bus2, w ? wd : exp_rd);
`ifdef DMEM_MISALIGN_ERR_EN
                check_value({tag, "_err"}, 64'(err2), 64'(a[2:0] != 3'b000));
`endif
            end else begin
                check_value({tag, "_released"}, bus2, d2);
            end
        end
        check_value({tag, "_ready_seen"}, 64'(seen), 64'd1);
        @(posedge clk); #1;
        req2 = 1'b0; drv2 = 1'b1; d2 = 64'h0;
        @(negedge clk);
        check_value({tag, "_ready_drop"}, 64'(ready2), 64'd0);
        $display("txn %s addr=%h we=%b cycles=%0d bus=%h", tag, a, w, cyc, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_ready1;
        rst = 1'b1;
        addr2 = '0; we2 = 1'b0; req2 = 1'b0; d2 = '0; drv2 = 1'b1;
        addr1 = '0; we1 = 1'b0; req1 = 1'b0; d1 = '0; drv1 = 1'b1;

        // Reset for two cycles, then idle with no request.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_value("reset_ready2", 64'(ready2), 64'd0);
            check_value("reset_ready1", 64'(ready1), 64'd0);
            check_value("reset_bus2", bus2, d2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_value("idle_ready2", 64'(ready2), 64'd0);
            check_value("idle_bus2", bus2, d2);
        end
        $display("txn reset_idle done");

        txn("wr08", 6'h08, 1'b1, 64'hDEADBEEF_01234567, 6'h08, 64'h0);
        txn("rd08", 6'h08, 1'b0, 64'h0, 6'h08, 64'hDEADBEEF_01234567);

        // Address switched from index 2 to index 3 while waiting.
        txn("wr10", 6'h10, 1'b1, 64'h2222_2222_2222_2222, 6'h10, 64'h0);
        txn("wr18", 6'h18, 1'b1, 64'h3333_3333_3333_3333, 6'h18, 64'h0);
        txn("rd_midchg", 6'h10, 1'b0, 64'h0, 6'h18, 64'h2222_2222_2222_2222);

        // Reset during WAIT aborts the write to index 5.
        txn("wr28", 6'h28, 1'b1, 64'h1, 6'h28, 64'h0);
        @(posedge clk); #1;
        addr2 = 6'h28; we2 = 1'b1; d2 = 64'hFFFF; drv2 = 1'b1; req2 = 1'b1;
        @(negedge clk);
        check_value("rstw_wait_ready", 64'(ready2), 64'd0);
        rst = 1'b1; req2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("rstw_no_ready", 64'(ready2), 64'd0);
        end
        $display("txn rst_in_wait addr=28 aborted");
        d2 = 64'h0;
        txn("rd28", 6'h28, 1'b0, 64'h0, 6'h28, 64'h1);

        // Reset on the RESP edge suppresses the commit to index 4.
        txn("wr20", 6'h20, 1'b1, 64'hAAAA, 6'h20, 64'h0);
        @(posedge clk); #1;
        addr2 = 6'h20; we2 = 1'b1; d2 = 64'hBBBB; drv2 = 1'b1; req2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_value("rstr_resp_ready", 64'(ready2), 64'd1);
        rst = 1'b1; req2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("rstr_ready_low", 64'(ready2), 64'd0);
        $display("txn rst_in_resp addr=20 aborted");
        d2 = 64'h0;
        txn("rd20", 6'h20, 1'b0, 64'h0, 6'h20, 64'hAAAA);

`ifdef DMEM_MISALIGN_ERR_EN
        txn("wr0b_mis", 6'h0B, 1'b1, 64'h5555, 6'h0B, 64'h0);
        txn("rd08_after_mis", 6'h08, 1'b0, 64'h0, 6'h08, 64'hDEADBEEF_01234567);
        txn("rd0b_mis", 6'h0B, 1'b0, 64'h0, 6'h0B, 64'h0);
`else
        txn("wr0b", 6'h0B, 1'b1, 64'h5555, 6'h0B, 64'h0);
        txn("rd08_after", 6'h08, 1'b0, 64'h0, 6'h08, 64'h5555);
        txn("rd0f", 6'h0F, 1'b0, 64'h0, 6'h0F, 64'h5555);
`endif

        // LATENCY=1 with req held: write idx 0, write idx 7, read idx 7.
        exp_ready1 = 7'b0101010;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin addr1 = 6'h00; we1 = 1'b1; d1 = 64'h1111; drv1 = 1'b1; req1 = 1'b1; end
                1: begin addr1 = 6'h38; d1 = 64'h7777; end
                3: begin addr1 = 6'h38; we1 = 1'b0; drv1 = 1'b0; end
                5: begin req1 = 1'b0; end
                default: ;
            endcase
            @(negedge clk);
            check_value($sformatf("b2b_ready_c%0d", c), 64'(ready1), 64'(exp_ready1[c]));
            if (c == 5) check_value("b2b_rd7_data", bus1, 64'h7777);
            $display("txn b2b cycle=%0d ready=%b bus=%h", c, ready1, bus1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
